pipe_cla_adder: RTL

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla4_group.sv | 24 ++
 rtl/pipe_cla_adder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and carry-lookahead helper for the pipelined CLA adder.
// Latency: none (package). Backpressure: n/a.
// Group carries come from flat sum-of-products terms, so no carry ripples through a group.
package cla_pkg;

  localparam int GROUP_W = 4;

  function automatic logic [GROUP_W:0] group_carries(
    input logic [GROUP_W-1:0] g,
    input logic [GROUP_W-1:0] p,
    input logic               ci
  );
    logic [GROUP_W:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

endpackage

// File: rtl/cla4_group.sv
// One 4-bit carry-lookahead group: sum bits and group carry-out.
// Latency: purely combinational. Backpressure: none.
// Carries are taken from group_carries, never rippled bit to bit.
module cla4_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] s,
  output logic               co
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W:0]   c;

  assign g  = a & b;
  assign p  = a ^ b;
  assign c  = group_carries(g, p, ci);
  assign s  = p ^ c[GROUP_W-1:0];
  assign co = c[GROUP_W];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined adder, one 4-bit CLA group per stage; CLA_SUB_EN adds a subtract mode (a - b).
// Latency: WIDTH/4 cycles, one result per cycle. Backpressure: whole pipe freezes while
// out_valid && !out_ready; in_ready mirrors that advance condition combinationally.
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGROUP = WIDTH / GROUP_W;
  localparam int LAST   = NGROUP - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

`ifdef CLA_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c0         = cin;
`endif

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar k = 0; k < NGROUP; k++) begin : g_stg
    localparam int REM = WIDTH - GROUP_W * k;
    localparam int SW  = GROUP_W * (k + 1);

    // Operand bits still to be added (this group and above), and everything stage k registers.
    logic [REM-1:0]     a_src;
    logic [REM-1:0]     b_src;
    logic               ci_src;
    logic               vld_src;
    logic               amsb_src;
    logic               bmsb_src;
    logic               ld;
    logic [SW-1:0]      sum_d;
    logic [GROUP_W-1:0] gs;
    logic               gco;
    logic               vld_q;
    logic               cry_q;
    logic               amsb_q;
    logic               bmsb_q;
    logic [SW-1:0]      sum_q;

    if (k == 0) begin : g_head
      assign a_src    = a;
      assign b_src    = b_eff;
      assign ci_src   = c0;
      assign vld_src  = in_valid;
      assign amsb_src = a[WIDTH-1];
      assign bmsb_src = b_eff[WIDTH-1];
      assign sum_d    = gs;
      assign ld       = advance & in_valid;
    end else begin : g_body
      assign a_src    = g_stg[k-1].g_skew.a_q;
      assign b_src    = g_stg[k-1].g_skew.b_q;
      assign ci_src   = g_stg[k-1].cry_q;
      assign vld_src  = g_stg[k-1].vld_q;
      assign amsb_src = g_stg[k-1].amsb_q;
      assign bmsb_src = g_stg[k-1].bmsb_q;
      assign sum_d    = {gs, g_stg[k-1].sum_q};
      assign ld       = advance;
    end

    cla4_group u_grp (
      .a  (a_src[GROUP_W-1:0]),
      .b  (b_src[GROUP_W-1:0]),
      .ci (ci_src),
      .s  (gs),
      .co (gco)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        cry_q  <= 1'b0;
        amsb_q <= 1'b0;
        bmsb_q <= 1'b0;
        sum_q  <= '0;
      end else begin
        if (advance) vld_q <= vld_src;
        if (ld) begin
          cry_q  <= gco;
          amsb_q <= amsb_src;
          bmsb_q <= bmsb_src;
          sum_q  <= sum_d;
        end
      end
    end

    // Upper operand bits ride along so later groups see their own transaction.
    if (k < LAST) begin : g_skew
      logic [REM-GROUP_W-1:0] a_q;
      logic [REM-GROUP_W-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= a_src[REM-1:GROUP_W];
          b_q <= b_src[REM-1:GROUP_W];
        end
      end
    end
  end

  assign out_valid = g_stg[LAST].vld_q;
  assign sum       = g_stg[LAST].sum_q;
  assign cout      = g_stg[LAST].cry_q;
  assign ovf       = (g_stg[LAST].amsb_q == g_stg[LAST].bmsb_q)
                  && (sum[WIDTH-1] != g_stg[LAST].amsb_q);

endmodule
